// File: rtl/pwm_gate_protect.sv
// -----------------------------------------------------------------------------
// pwm_gate_protect
// Protection stage between the three-phase PWM generator and the gate-driver
// pins. Passes the six gate requests through one register stage while armed,
// arms only on a PWM period boundary, and forces every gate low on a filtered
// external fault or a same-phase shoot-through. A trip and its cause stay
// latched until software clears them with the fault gone.
//
// Optional build macro: PWM_PROTECT_DEADTIME_CHECK_EN
//   When defined, a per-phase minimum-gap check is added (parameter MIN_GAP):
//   turning one side of a phase on too soon after the other side turned off is
//   treated as shoot-through. When undefined, only simultaneous overlap counts.
// -----------------------------------------------------------------------------
module pwm_gate_protect #(
  parameter int FILTER_LEN = 4
`ifdef PWM_PROTECT_DEADTIME_CHECK_EN
  ,
  parameter int MIN_GAP = 8
`endif
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] PWM_In,
  input  logic [2:0] PWM_LSS_In,
  input  logic       Period_Tick,
  input  logic       Enable,
  input  logic       Fault_n,
  input  logic       Clear,
  output logic [2:0] PWM_Out,
  output logic [2:0] PWM_LSS_Out,
  output logic       Armed,
  output logic       Tripped,
  output logic [1:0] Trip_Cause
);

  // Fault filter counter sizing; the counter saturates at FILTER_LEN.
  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_RUN      = 2'd1,
    ST_TRIP     = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [CNT_W-1:0] filt_cnt_r;
  logic             filt_idle_s;
  logic             fault_hit_s;
  logic             overlap_s;
  logic             st_hit_s;

  logic [2:0]       pwm_out_r;
  logic [2:0]       lss_out_r;
  logic             armed_r;
  logic             tripped_r;
  logic [1:0]       cause_r;

  logic [2:0]       pwm_nxt_s;
  logic [2:0]       lss_nxt_s;
  logic [1:0]       cause_nxt_s;

  // ---------------------------------------------------------------------------
  // External fault filter. Runs in every state so that the clear and arm
  // conditions can see whether the fault line has been quiet.
  // ---------------------------------------------------------------------------

  // Count consecutive low Fault_n samples, saturating; any high sample restarts
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      filt_cnt_r <= CNT_ZERO;
    end else if (Fault_n) begin
      filt_cnt_r <= CNT_ZERO;
    end else if (filt_cnt_r != CNT_MAX) begin
      filt_cnt_r <= filt_cnt_r + CNT_ONE;
    end else begin
      filt_cnt_r <= filt_cnt_r;
    end
  end

  // The FILTER_LEN-th consecutive low sample (and every one after it) is a hit
  assign fault_hit_s = !Fault_n && ((filt_cnt_r == CNT_PRE) || (filt_cnt_r == CNT_MAX));
  assign filt_idle_s = (filt_cnt_r == CNT_ZERO);

  // Both switches of one phase requested on in the same cycle
  assign overlap_s = |(PWM_In & PWM_LSS_In);

`ifdef PWM_PROTECT_DEADTIME_CHECK_EN
  // ---------------------------------------------------------------------------
  // Minimum-gap check. A falling edge on either side of a phase opens a window
  // of MIN_GAP cycles; a rising edge on the side opposite to one that fell
  // inside that window is a shoot-through. Rising again on the same side is
  // legal (that is just a short low pulse, not a crossover).
  // ---------------------------------------------------------------------------
  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP);

  logic [2:0] pwm_prev_r;
  logic [2:0] lss_prev_r;
  logic [2:0] h_fell_r;
  logic [2:0] l_fell_r;
  logic [7:0] gap_cnt_r [3];

  logic [2:0] h_fall_s;
  logic [2:0] l_fall_s;
  logic [2:0] h_rise_s;
  logic [2:0] l_rise_s;
  logic [2:0] gap_viol_s;

  assign h_fall_s = pwm_prev_r & ~PWM_In;
  assign l_fall_s = lss_prev_r & ~PWM_LSS_In;
  assign h_rise_s = ~pwm_prev_r & PWM_In;
  assign l_rise_s = ~lss_prev_r & PWM_LSS_In;

  // Track previous inputs and run one gap window per phase
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pwm_prev_r <= 3'b000;
      lss_prev_r <= 3'b000;
      h_fell_r   <= 3'b000;
      l_fell_r   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        gap_cnt_r[i] <= 8'd0;
      end
    end else begin
      pwm_prev_r <= PWM_In;
      lss_prev_r <= PWM_LSS_In;
      for (int i = 0; i < 3; i++) begin
        if (h_fall_s[i] || l_fall_s[i]) begin
          gap_cnt_r[i] <= GAP_LOAD;
          h_fell_r[i]  <= h_fall_s[i];
          l_fell_r[i]  <= l_fall_s[i];
        end else if (gap_cnt_r[i] != 8'd0) begin
          gap_cnt_r[i] <= gap_cnt_r[i] - 8'd1;
        end else begin
          gap_cnt_r[i] <= gap_cnt_r[i];
        end
      end
    end
  end

  // Flag an opposite-side turn-on while the phase's gap window is still open
  always_comb begin
    gap_viol_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (gap_cnt_r[i] != 8'd0) begin
        gap_viol_s[i] = (h_fell_r[i] && l_rise_s[i]) || (l_fell_r[i] && h_rise_s[i]);
      end else begin
        gap_viol_s[i] = 1'b0;
      end
    end
  end

  assign st_hit_s = overlap_s || (|gap_viol_s);
`else
  assign st_hit_s = overlap_s;
`endif

  // ---------------------------------------------------------------------------
  // Protection state machine.
  // ---------------------------------------------------------------------------

  // Next state, next gate outputs and next trip cause; gates default to off
  always_comb begin
    state_nxt_s = state_r;
    pwm_nxt_s   = 3'b000;
    lss_nxt_s   = 3'b000;
    cause_nxt_s = cause_r;
    case (state_r)
      ST_DISARMED: begin
        if (fault_hit_s) begin
          state_nxt_s = ST_TRIP;
          cause_nxt_s = 2'b01;
        end else if (Enable && Period_Tick && filt_idle_s && !st_hit_s) begin
          // Arm on the period boundary; gates stay off on this edge so the
          // first pass-through is a whole period.
          state_nxt_s = ST_RUN;
          cause_nxt_s = 2'b00;
        end else begin
          state_nxt_s = ST_DISARMED;
          cause_nxt_s = 2'b00;
        end
      end
      ST_RUN: begin
        if (fault_hit_s || st_hit_s) begin
          // Protection wins over a simultaneous disarm request.
          state_nxt_s = ST_TRIP;
          cause_nxt_s = {st_hit_s, fault_hit_s};
        end else if (!Enable) begin
          state_nxt_s = ST_DISARMED;
        end else begin
          state_nxt_s = ST_RUN;
          pwm_nxt_s   = PWM_In;
          lss_nxt_s   = PWM_LSS_In;
        end
      end
      ST_TRIP: begin
        // The cause is frozen; only a clear with the fault line fully quiet
        // releases the trip. A clear that is too early is simply dropped.
        if (Clear && Fault_n && filt_idle_s) begin
          state_nxt_s = ST_DISARMED;
          cause_nxt_s = 2'b00;
        end else begin
          state_nxt_s = ST_TRIP;
        end
      end
      default: begin
        // Unreachable encoding: fall back to the safe, gates-off state.
        state_nxt_s = ST_DISARMED;
        cause_nxt_s = 2'b00;
      end
    endcase
  end

  // State register and registered gate/status outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r   <= ST_DISARMED;
      pwm_out_r <= 3'b000;
      lss_out_r <= 3'b000;
      armed_r   <= 1'b0;
      tripped_r <= 1'b0;
      cause_r   <= 2'b00;
    end else begin
      state_r   <= state_nxt_s;
      pwm_out_r <= pwm_nxt_s;
      lss_out_r <= lss_nxt_s;
      armed_r   <= (state_nxt_s == ST_RUN);
      tripped_r <= (state_nxt_s == ST_TRIP);
      cause_r   <= cause_nxt_s;
    end
  end

  assign PWM_Out     = pwm_out_r;
  assign PWM_LSS_Out = lss_out_r;
  assign Armed       = armed_r;
  assign Tripped     = tripped_r;
  assign Trip_Cause  = cause_r;

endmodule

// File: tb/tb_pwm_gate_protect.sv
// -----------------------------------------------------------------------------
// tb_pwm_gate_protect
// Table-driven bench: each record holds one cycle of inputs and the outputs
// expected right after the following rising edge. Expected records are queued
// when the inputs are driven and popped when the DUT outputs are sampled.
// With PWM_PROTECT_DEADTIME_CHECK_EN defined the minimum-gap sequence runs
// instead of the overlap-only table.
// -----------------------------------------------------------------------------
module tb_pwm_gate_protect;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       tick;
    logic       fault_n;
    logic       clr;
    logic [2:0] pwm;
    logic [2:0] lss;
  } stim_t;

  typedef struct packed {
    logic [2:0] po;
    logic [2:0] lo;
    logic       arm;
    logic       trp;
    logic [1:0] cause;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t e;
  } vec_t;

  logic       Clk;
  logic       Reset_n;
  logic [2:0] PWM_In;
  logic [2:0] PWM_LSS_In;
  logic       Period_Tick;
  logic       Enable;
  logic       Fault_n;
  logic       Clear;
  logic [2:0] PWM_Out;
  logic [2:0] PWM_LSS_Out;
  logic       Armed;
  logic       Tripped;
  logic [1:0] Trip_Cause;

  vec_t  vecs[$];
  resp_t exp_q[$];
  int    n_checks;
  int    n_fail;

  pwm_gate_protect #(.FILTER_LEN(4)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .PWM_In      (PWM_In),
    .PWM_LSS_In  (PWM_LSS_In),
    .Period_Tick (Period_Tick),
    .Enable      (Enable),
    .Fault_n     (Fault_n),
    .Clear       (Clear),
    .PWM_Out     (PWM_Out),
    .PWM_LSS_Out (PWM_LSS_Out),
    .Armed       (Armed),
    .Tripped     (Tripped),
    .Trip_Cause  (Trip_Cause)
  );

  // Free-running clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic stim_t mk_s(input logic r, input logic en, input logic tk,
                                 input logic fn, input logic cl,
                                 input logic [2:0] p, input logic [2:0] l);
    stim_t s;
    s.rst_n = r; s.en = en; s.tick = tk; s.fault_n = fn; s.clr = cl;
    s.pwm = p; s.lss = l;
    return s;
  endfunction

  function automatic resp_t mk_r(input logic [2:0] po, input logic [2:0] lo,
                                 input logic a, input logic t, input logic [1:0] c);
    resp_t e;
    e.po = po; e.lo = lo; e.arm = a; e.trp = t; e.cause = c;
    return e;
  endfunction

  task automatic add(input stim_t s, input resp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle, queue its expectation, then sample #1 after the edge
  task automatic step(input stim_t s, input resp_t e, input int idx);
    resp_t exp_v;
    resp_t act_v;
    Reset_n     = s.rst_n;
    Enable      = s.en;
    Period_Tick = s.tick;
    Fault_n     = s.fault_n;
    Clear       = s.clr;
    PWM_In      = s.pwm;
    PWM_LSS_In  = s.lss;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    exp_v = exp_q.pop_front();
    act_v = {PWM_Out, PWM_LSS_Out, Armed, Tripped, Trip_Cause};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL vec%0d: got po=%b lo=%b arm=%b trp=%b cause=%b, want po=%b lo=%b arm=%b trp=%b cause=%b",
               idx, act_v.po, act_v.lo, act_v.arm, act_v.trp, act_v.cause,
               exp_v.po, exp_v.lo, exp_v.arm, exp_v.trp, exp_v.cause);
    end
  endtask

  resp_t z;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    Reset_n     = 1'b0;
    Enable      = 1'b0;
    Period_Tick = 1'b0;
    Fault_n     = 1'b1;
    Clear       = 1'b0;
    PWM_In      = 3'b000;
    PWM_LSS_In  = 3'b000;
    z = mk_r(3'b000, 3'b000, 1'b0, 1'b0, 2'b00);

`ifndef PWM_PROTECT_DEADTIME_CHECK_EN
    // Reset state
    add(mk_s(1'b0,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000), z);
    add(mk_s(1'b0,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000), z);
    // Disarmed: no pass-through without a tick
    for (int i = 0; i < 3; i++)
      add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b101,3'b000), z);
    // Tick without Enable, tick with overlap, tick with filter count non-zero
    add(mk_s(1'b1,1'b0,1'b1,1'b1,1'b0,3'b101,3'b000), z);
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b001,3'b001), z);
    add(mk_s(1'b1,1'b1,1'b0,1'b0,1'b0,3'b000,3'b000), z);
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b000,3'b000), z);
    // Arm: outputs still 0 on the arming edge, pass-through from the next
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b101,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b101,3'b010), mk_r(3'b101,3'b010,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b011,3'b100), mk_r(3'b011,3'b100,1'b1,1'b0,2'b00));
    // Three low fault samples then high: no trip
    for (int i = 0; i < 3; i++)
      add(mk_s(1'b1,1'b1,1'b0,1'b0,1'b0,3'b001,3'b000), mk_r(3'b001,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b110,3'b001), mk_r(3'b110,3'b001,1'b1,1'b0,2'b00));
    // Four low fault samples: trip on the fourth
    for (int i = 0; i < 3; i++)
      add(mk_s(1'b1,1'b1,1'b0,1'b0,1'b0,3'b100,3'b000), mk_r(3'b100,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b0,1'b0,3'b100,3'b000), mk_r(3'b000,3'b000,1'b0,1'b1,2'b01));
    // Clear with fault present (plus overlap): ignored, cause frozen
    add(mk_s(1'b1,1'b1,1'b0,1'b0,1'b1,3'b010,3'b010), mk_r(3'b000,3'b000,1'b0,1'b1,2'b01));
    // Clear with Fault_n high but count still non-zero: ignored
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b1,3'b000,3'b000), mk_r(3'b000,3'b000,1'b0,1'b1,2'b01));
    // Clear accepted
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b1,3'b000,3'b000), z);
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b111,3'b000), z);
    // Re-arm, pass, shoot-through trip
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b010,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b010,3'b000), mk_r(3'b010,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b010,3'b010), mk_r(3'b000,3'b000,1'b0,1'b1,2'b10));
    // Enable/tick have no effect in TRIP
    add(mk_s(1'b1,1'b0,1'b1,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b0,1'b1,2'b10));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b1,3'b000,3'b000), z);
    // Fault and shoot-through together: cause 11
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00));
    for (int i = 0; i < 3; i++)
      add(mk_s(1'b1,1'b1,1'b0,1'b0,1'b0,3'b001,3'b100), mk_r(3'b001,3'b100,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b0,1'b0,3'b010,3'b010), mk_r(3'b000,3'b000,1'b0,1'b1,2'b11));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b0,1'b1,2'b11));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b1,3'b000,3'b000), z);
    // Clear outside TRIP ignored; arm; pass; disarm via Enable low
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b1,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b101,3'b010), mk_r(3'b101,3'b010,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b0,1'b0,1'b1,1'b0,3'b111,3'b000), z);
    // Hit takes precedence over Enable low; then reset mid-trip
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b0,1'b0,1'b1,1'b0,3'b001,3'b001), mk_r(3'b000,3'b000,1'b0,1'b1,2'b10));
    add(mk_s(1'b0,1'b1,1'b0,1'b1,1'b0,3'b000,3'b000), z);
    add(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00));
    add(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b110,3'b001), mk_r(3'b110,3'b001,1'b1,1'b0,2'b00));

    foreach (vecs[i]) step(vecs[i].s, vecs[i].e, i);

    // Hand-written: fault trip while disarmed, then reset clears the filter
    step(mk_s(1'b1,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000), z, 100);
    for (int i = 0; i < 3; i++)
      step(mk_s(1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000), z, 101 + i);
    step(mk_s(1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b0,1'b1,2'b01), 104);
    step(mk_s(1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000), z, 105);
    step(mk_s(1'b1,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000), z, 106);
    step(mk_s(1'b1,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000), z, 107);
`else
    // Hand-written minimum-gap sequence (MIN_GAP = 8)
    step(mk_s(1'b0,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000), z, 200);
    step(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00), 201);
    step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b001,3'b000), mk_r(3'b001,3'b000,1'b1,1'b0,2'b00), 202);
    // High side of phase 0 falls; low side rises four cycles later: trip
    for (int i = 0; i < 4; i++)
      step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00), 203 + i);
    step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b000,3'b001), mk_r(3'b000,3'b000,1'b0,1'b1,2'b10), 207);
    step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b1,3'b000,3'b000), z, 208);
    for (int i = 0; i < 10; i++)
      step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b000,3'b000), z, 209 + i);
    step(mk_s(1'b1,1'b1,1'b1,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00), 220);
    step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b001,3'b000), mk_r(3'b001,3'b000,1'b1,1'b0,2'b00), 221);
    // Same fall, low side rises nine cycles later: window closed, no trip
    for (int i = 0; i < 9; i++)
      step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b000,3'b000), mk_r(3'b000,3'b000,1'b1,1'b0,2'b00), 222 + i);
    step(mk_s(1'b1,1'b1,1'b0,1'b1,1'b0,3'b000,3'b001), mk_r(3'b000,3'b001,1'b1,1'b0,2'b00), 231);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_gate_protect.md
Name: pwm_gate_protect

Overview:
- Downstream stage of the three-phase PWM generator. Sits between the generator's high-side/low-side outputs and the gate-driver pins.
- Registers and passes the six gate signals when armed. Arms only on a PWM period boundary, so a started period is never truncated.
- Forces all gates low on a filtered external fault or a same-phase shoot-through. Latches the trip and its cause until software clears it.

Parameters:
- FILTER_LEN, 4: consecutive low samples of Fault_n required to trip; legal range 1..255; 1 = trip on first low sample.

Ports:
- Clk  in  1  clock
- Reset_n  in  1  reset, synchronous, active-low
- PWM_In  in  3  high-side gate requests from the PWM generator, one bit per phase
- PWM_LSS_In  in  3  low-side gate requests from the PWM generator
- Period_Tick  in  1  one-cycle pulse at each PWM period boundary (generator interrupt-active output)
- Enable  in  1  software arm request, level
- Fault_n  in  1  external driver/overcurrent fault, active-low, synchronised upstream
- Clear  in  1  one-cycle trip-clear request
- PWM_Out  out  3  gated high-side outputs
- PWM_LSS_Out  out  3  gated low-side outputs
- Armed  out  1  state == RUN
- Tripped  out  1  state == TRIP
- Trip_Cause  out  2  00 none, 01 fault, 10 shoot-through, 11 both in same cycle

Behaviour:
- Reset: state DISARMED; PWM_Out=0; PWM_LSS_Out=0; Armed=0; Tripped=0; Trip_Cause=00; filter count=0. Reset mid-trip clears everything.
- Fault filter:
  - Counter of width clog2(FILTER_LEN+1).
  - Fault_n==0: counter increments, saturating at FILTER_LEN. Fault_n==1: counter goes to 0.
  - fault_hit = (Fault_n==0) && (count==FILTER_LEN-1 or count==FILTER_LEN).
  - The filter runs in all states.
- Shoot-through: st_hit = |(PWM_In & PWM_LSS_In), evaluated on the raw inputs of the current cycle.
- All outputs are registered. In RUN, pass-through latency is 1 cycle.
- DISARMED:
  - Outputs 0.
  - Goes to RUN when Enable && Period_Tick && count==0 && !st_hit. Outputs stay 0 on that edge; first pass-through is on the next edge.
  - fault_hit in DISARMED: go to TRIP with cause 01.
- RUN:
  - PWM_Out<=PWM_In; PWM_LSS_Out<=PWM_LSS_In.
  - fault_hit or st_hit: go to TRIP. On that same edge, outputs<=0 and the current inputs are not passed. Trip_Cause<={st_hit,fault_hit}.
  - Enable==0 (no hit): go to DISARMED with outputs<=0 on that edge.
  - A hit takes precedence over Enable==0.
- TRIP:
  - Outputs held 0; Tripped=1; Trip_Cause frozen. Further hits are ignored and cause bits are not OR-ed in.
  - Clear && Fault_n==1 && count==0: go to DISARMED with Trip_Cause<=00.
  - Clear while the fault is still present or the filter count is non-zero: ignored; stay in TRIP. No pending-clear memory.
  - Enable has no effect in TRIP.
- Period_Tick outside DISARMED is ignored.
- Clear outside TRIP is ignored.

Optional Feature:
- Macro PWM_PROTECT_DEADTIME_CHECK_EN.
- Defined: adds a per-phase minimum-gap check.
  - A 3-phase set of 8-bit down-counters is loaded with MIN_GAP (extra parameter, default 8) whenever either input of that phase falls.
  - The rising edge of the opposite-side input of the same phase while its counter is non-zero counts as st_hit, giving cause 10.
  - Counters reset to 0.
- Undefined: the MIN_GAP parameter and counters are absent; shoot-through is only simultaneous overlap.

Test Plan:
- Arm: after reset, Enable=1, Fault_n=1, Period_Tick pulse at cycle 10 -> Armed=1 at edge 10; PWM_In=3'b101 at cycle 11 -> PWM_Out=3'b101 after edge 11, 0 before.
- Fault filter (FILTER_LEN=4), in RUN:
  - Fault_n low for 3 cycles, then high -> no trip, outputs still passing.
  - Fault_n low for 4 cycles -> Tripped=1, outputs=0, Trip_Cause=01 on the 4th low edge.
- Shoot-through: in RUN, PWM_In=3'b010 with PWM_LSS_In=3'b010 for 1 cycle -> outputs 0 on that edge, Trip_Cause=10. Simultaneously with the 4th Fault_n low sample -> Trip_Cause=11.
- Clear rules:
  - Clear while Fault_n=0 -> stays TRIP, cause unchanged.
  - Fault_n=1 for 1 cycle, then Clear -> DISARMED, cause 00, outputs 0 until the next Enable+Period_Tick.
- Disarm: in RUN, Enable drops at cycle 50 -> PWM_Out=PWM_LSS_Out=0 at edge 50, Armed=0. Reset_n low during TRIP -> all outputs 0 and cause 00 next edge.
- Macro on (MIN_GAP=8): PWM_In[0] falls at cycle 20, PWM_LSS_In[0] rises at cycle 24 -> trip with cause 10. The same rise at cycle 29 -> no trip.
